// File: rtl/seg7_pkg.sv
// Shared 7-segment constants and filter state encoding for the display encoder and the scan decoder.
package seg7_pkg;

   localparam int unsigned SEG_W = 7;
   localparam int unsigned BCD_W = 4;

   // Active-low segment patterns, bit6 = a down to bit0 = g
   localparam logic [SEG_W-1:0] SEG_0     = 7'b0000001;
   localparam logic [SEG_W-1:0] SEG_1     = 7'b1001111;
   localparam logic [SEG_W-1:0] SEG_2     = 7'b0010010;
   localparam logic [SEG_W-1:0] SEG_3     = 7'b0000110;
   localparam logic [SEG_W-1:0] SEG_4     = 7'b1001100;
   localparam logic [SEG_W-1:0] SEG_5     = 7'b0100100;
   localparam logic [SEG_W-1:0] SEG_6     = 7'b0100000;
   localparam logic [SEG_W-1:0] SEG_7     = 7'b0001111;
   localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
   localparam logic [SEG_W-1:0] SEG_9     = 7'b0000100;
   localparam logic [SEG_W-1:0] SEG_DASH  = 7'b1111110;
   localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

   localparam logic [BCD_W-1:0] BCD_INVALID = 4'hF;

   // Glitch filter states
   localparam logic [0:0] ST_SETTLE = 1'b0;
   localparam logic [0:0] ST_HELD   = 1'b1;

   // Forward encoding used by the display driver side
   function automatic logic [SEG_W-1:0] bcd_to_seg(input logic [BCD_W-1:0] bcd);
      logic [SEG_W-1:0] seg;
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational inverse of the BCD-to-segment encoder; anything outside 0..9 is flagged illegal.
module seg7_to_bcd
   import seg7_pkg::*;
(
   input  logic [6:0] seg_n,
   output logic [3:0] bcd,
   output logic       legal
);

   always_comb begin
      bcd   = BCD_INVALID;
      legal = 1'b1;
      case (seg_n)
         SEG_0:   bcd = 4'd0;
         SEG_1:   bcd = 4'd1;
         SEG_2:   bcd = 4'd2;
         SEG_3:   bcd = 4'd3;
         SEG_4:   bcd = 4'd4;
         SEG_5:   bcd = 4'd5;
         SEG_6:   bcd = 4'd6;
         SEG_7:   bcd = 4'd7;
         SEG_8:   bcd = 4'd8;
         SEG_9:   bcd = 4'd9;
         default: legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers per-digit BCD values from a multiplexed active-low 7-segment bus,
// with glitch filtering, illegal-pattern flags and aging of stale digits.
module seg7_scan_decoder
   import seg7_pkg::*;
#(
   parameter int unsigned NUM_DIGITS     = 4,
   parameter int unsigned STABLE_CYCLES  = 16,
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [6:0]              seg_n,
   input  logic [NUM_DIGITS-1:0]   an_n,
   output logic [4*NUM_DIGITS-1:0] digit_val,
   output logic [NUM_DIGITS-1:0]   digit_valid,
   output logic [NUM_DIGITS-1:0]   digit_err,
   output logic                    an_err,
   output logic                    update
);

   localparam int unsigned BUS_W   = NUM_DIGITS + SEG_W;
   localparam int unsigned VAL_W   = BCD_W * NUM_DIGITS;
   localparam int unsigned CNT_W   = $clog2(STABLE_CYCLES);
   localparam int unsigned EPOCH_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [EPOCH_W-1:0] EPOCH_LAST = EPOCH_W'(TIMEOUT_CYCLES - 1);

   // Synchronizers idle at all-ones (blank, no anode) so reset never looks like a multi-anode frame
   logic [BUS_W-1:0] sync1;
   logic [BUS_W-1:0] sync2;
   logic [BUS_W-1:0] prev;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= '1;
         sync2 <= '1;
         prev  <= '1;
      end else begin
         sync1 <= {an_n, seg_n};
         sync2 <= sync1;
         prev  <= sync2;
      end
   end

   logic match_c;
   assign match_c = (sync2 == prev);

   // Stability filter: one accept strobe per stable period
   logic [0:0]       state;
   logic [0:0]       state_nxt;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_nxt;
   logic             accept_c;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_SETTLE;
         count <= '0;
      end else begin
         state <= state_nxt;
         count <= count_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      count_nxt = count;
      accept_c  = 1'b0;
      case (state)
         ST_SETTLE: begin
            if (!match_c) begin
               count_nxt = '0;
            end else if (count == CNT_LAST) begin
               accept_c  = 1'b1;
               state_nxt = ST_HELD;
            end else begin
               count_nxt = count + CNT_W'(1);
            end
         end
         ST_HELD: begin
            if (!match_c) begin
               state_nxt = ST_SETTLE;
               count_nxt = '0;
            end
         end
         default: begin
            state_nxt = ST_SETTLE;
            count_nxt = '0;
         end
      endcase
   end

   // Decode path on the synchronized bus
   logic [SEG_W-1:0]      seg_sync_c;
   logic [NUM_DIGITS-1:0] an_low_c;
   logic                  an_none_c;
   logic                  an_multi_c;
   logic [BCD_W-1:0]      bcd_c;
   logic                  legal_c;

   assign seg_sync_c = sync2[SEG_W-1:0];
   assign an_low_c   = ~sync2[BUS_W-1:SEG_W];
   assign an_none_c  = (an_low_c == '0);
   assign an_multi_c = ((an_low_c & (an_low_c - NUM_DIGITS'(1))) != '0);

   seg7_to_bcd u_seg7_to_bcd (
      .seg_n (seg_sync_c),
      .bcd   (bcd_c),
      .legal (legal_c)
   );

   // Free-running aging epoch
   logic [EPOCH_W-1:0] epoch;
   logic               wrap_c;
   assign wrap_c = (epoch == EPOCH_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         epoch <= '0;
      end else begin
         epoch <= wrap_c ? '0 : epoch + EPOCH_W'(1);
      end
   end

   // Next output state; an accept on the wrap cycle overrides aging for that digit
   logic [NUM_DIGITS-1:0] refreshed;
   logic [NUM_DIGITS-1:0] refreshed_nxt;
   logic [NUM_DIGITS-1:0] hit_c;
   logic [VAL_W-1:0]      val_nxt;
   logic [NUM_DIGITS-1:0] valid_nxt;
   logic [NUM_DIGITS-1:0] err_nxt;
   logic                  an_err_nxt;
   logic                  update_nxt;

   always_comb begin
      val_nxt       = digit_val;
      valid_nxt     = digit_valid;
      err_nxt       = digit_err;
      an_err_nxt    = an_err;
      refreshed_nxt = refreshed;
      hit_c         = '0;
      if (accept_c && !an_none_c) begin
         if (an_multi_c) begin
            an_err_nxt = 1'b1;
         end else begin
            hit_c = an_low_c;
         end
      end
      if (wrap_c) begin
         valid_nxt     = digit_valid & refreshed;
         refreshed_nxt = '0;
      end
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
         if (hit_c[i]) begin
            val_nxt[BCD_W*i +: BCD_W] = bcd_c;
            valid_nxt[i]              = legal_c;
            err_nxt[i]                = !legal_c;
            refreshed_nxt[i]          = 1'b1;
         end
      end
      update_nxt = (val_nxt != digit_val) || (valid_nxt != digit_valid) || (err_nxt != digit_err);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         digit_val   <= '0;
         digit_valid <= '0;
         digit_err   <= '0;
         an_err      <= 1'b0;
         update      <= 1'b0;
         refreshed   <= '0;
      end else begin
         digit_val   <= val_nxt;
         digit_valid <= valid_nxt;
         digit_err   <= err_nxt;
         an_err      <= an_err_nxt;
         update      <= update_nxt;
         refreshed   <= refreshed_nxt;
      end
   end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder: a run-length reference model predicts every update pulse.
module tb_seg7_scan_decoder;

   localparam int ND      = 4;
   localparam int STABLE  = 16;
   localparam int TIMEOUT = 100;
   localparam int BIG     = 100000;

   logic        clk   = 1'b0;
   logic        rst   = 1'b1;
   logic [6:0]  seg_n = 7'b1111111;
   logic [3:0]  an_n  = 4'b1111;
   logic [15:0] digit_val;
   logic [3:0]  digit_valid;
   logic [3:0]  digit_err;
   logic        an_err;
   logic        update;

   seg7_scan_decoder #(
      .NUM_DIGITS     (ND),
      .STABLE_CYCLES  (STABLE),
      .TIMEOUT_CYCLES (TIMEOUT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .seg_n       (seg_n),
      .an_n        (an_n),
      .digit_val   (digit_val),
      .digit_valid (digit_valid),
      .digit_err   (digit_err),
      .an_err      (an_err),
      .update      (update)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit mon_en = 1'b0;

   logic [6:0] pat_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

   function automatic int decode(input logic [6:0] s);
      for (int d = 0; d < 10; d++) if (s == pat_tab[d]) return d;
      return -1;
   endfunction

   // Reference model: an input value is taken once it has been seen unchanged for STABLE+1
   // consecutive edges, two edges late for the synchronizer.
   typedef struct { logic [10:0] bus; int run; } samp_t;
   typedef struct { int cyc; logic [15:0] val; logic [3:0] valid; logic [3:0] err; } exp_t;

   samp_t       pipe0, pipe1;
   logic [10:0] last_bus;
   int          run_len;
   int          cyc = 0;
   int          since_rst = 0;
   logic [15:0] m_val;
   logic [3:0]  m_valid, m_err, m_refr;
   logic        m_an_err;
   exp_t        exp_q[$];

   always @(posedge clk) begin
      samp_t       old;
      logic [3:0]  low;
      logic [15:0] pv;
      logic [3:0]  pvld, perr;
      int          sel, d;
      cyc++;
      if (rst) begin
         since_rst = 0;
         last_bus  = '1;
         run_len   = BIG;
         pipe0.bus = '1; pipe0.run = BIG;
         pipe1     = pipe0;
         m_val = '0; m_valid = '0; m_err = '0; m_refr = '0; m_an_err = 1'b0;
      end else begin
         since_rst++;
         if ({an_n, seg_n} == last_bus) run_len = (run_len < BIG) ? run_len + 1 : BIG;
         else run_len = 1;
         last_bus  = {an_n, seg_n};
         old       = pipe1;
         pipe1     = pipe0;
         pipe0.bus = last_bus;
         pipe0.run = run_len;
         pv = m_val; pvld = m_valid; perr = m_err;
         sel = -1;
         if (old.run == STABLE + 1) begin
            low = ~old.bus[10:7];
            if ($countones(low) > 1) m_an_err = 1'b1;
            else if ($countones(low) == 1)
               for (int i = 0; i < ND; i++) if (low[i]) sel = i;
         end
         if (since_rst % TIMEOUT == 0) begin
            m_valid = m_valid & m_refr;
            m_refr  = '0;
         end
         if (sel >= 0) begin
            d = decode(old.bus[6:0]);
            m_val[4*sel +: 4] = (d >= 0) ? 4'(d) : 4'hF;
            m_valid[sel] = (d >= 0);
            m_err[sel]   = (d < 0);
            m_refr[sel]  = 1'b1;
         end
         if (pv != m_val || pvld != m_valid || perr != m_err)
            exp_q.push_back('{cyc, m_val, m_valid, m_err});
      end
   end

   // Monitor: pop one expectation per update pulse
   int upd_count    = 0;
   int last_upd_cyc = -1;

   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         if (update === 1'b1) begin
            upd_count++;
            last_upd_cyc = cyc;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_update cyc=%0d got val=%h valid=%b err=%b required no pulse",
                        cyc, digit_val, digit_valid, digit_err);
            end else begin
               e = exp_q.pop_front();
               if (e.cyc != cyc || digit_val !== e.val || digit_valid !== e.valid || digit_err !== e.err) begin
                  errors++;
                  $display("FAIL update_payload cyc=%0d got val=%h valid=%b err=%b required cyc=%0d val=%h valid=%b err=%b",
                           cyc, digit_val, digit_valid, digit_err, e.cyc, e.val, e.valid, e.err);
               end
            end
         end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_update cyc=%0d got no pulse required val=%h valid=%b err=%b at cyc=%0d",
                     cyc, e.val, e.valid, e.err, e.cyc);
         end
         checks++;
         if (an_err !== m_an_err) begin
            errors++;
            $display("FAIL an_err cyc=%0d got %b required %b", cyc, an_err, m_an_err);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
      an_n  = a;
      seg_n = s;
      step(n);
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s got %0h required %0h", name, got, req);
      end
   endtask

   initial begin
      int          n0, u0, hits;
      logic [3:0]  a;
      int          scan_v[4] = '{9, 3, 0, 7};
      logic [6:0]  s;

      // Reset values
      step(3);
      check("rst_val", 32'(digit_val), 32'h0);
      check("rst_valid", 32'(digit_valid), 32'h0);
      check("rst_err", 32'(digit_err), 32'h0);
      check("rst_an_err", 32'(an_err), 32'h0);
      check("rst_update", 32'(update), 32'h0);
      rst    = 1'b0;
      mon_en = 1'b1;
      step(5);

      // First capture and its latency
      n0 = cyc;
      u0 = upd_count;
      drive(4'b0111, 7'b0010010, 30);
      check("latency_edge", 32'(last_upd_cyc), 32'(n0 + STABLE + 3));
      check("t1_pulses", 32'(upd_count - u0), 32'd1);
      check("t1_val3", 32'(digit_val[15:12]), 32'd2);
      check("t1_valid", 32'(digit_valid), 32'b1000);
      check("t1_err", 32'(digit_err), 32'b0000);

      // Glitch shorter than the filter window
      drive(4'b0111, 7'b0100100, 30);
      u0 = upd_count;
      drive(4'b0111, 7'b0000000, 10);
      drive(4'b0111, 7'b0100100, 30);
      check("glitch_pulses", 32'(upd_count - u0), 32'd0);
      check("glitch_val3", 32'(digit_val[15:12]), 32'd5);

      // Full scan, three frames
      for (int f = 0; f < 3; f++)
         for (int d = 0; d < 4; d++) begin
            a = 4'b0001 << d;
            s = pat_tab[scan_v[d]];
            drive(~a, s, 40);
         end
      check("scan_val", 32'(digit_val), 32'h7039);

      // Illegal pattern then multi-anode
      drive(4'b1101, 7'b1111110, 30);
      check("dash_val1", 32'(digit_val[7:4]), 32'hF);
      check("dash_err", 32'(digit_err), 32'b0010);
      check("dash_valid1", 32'(digit_valid[1]), 32'd0);
      drive(4'b0011, 7'b0000000, 30);
      check("multi_an_err", 32'(an_err), 32'd1);

      // Aging of digit 0
      drive(4'b1110, 7'b0000000, 30);
      check("age_cap_valid0", 32'(digit_valid[0]), 32'd1);
      an_n  = 4'b1111;
      seg_n = 7'b1111111;
      hits = 0;
      for (int i = 0; i < 300 && hits == 0; i++) begin
         step(1);
         if (!digit_valid[0]) hits = 1;
      end
      check("age_cleared", 32'(hits), 32'd1);
      check("age_on_wrap", 32'(since_rst % TIMEOUT), 32'd0);
      check("age_val0_held", 32'(digit_val[3:0]), 32'd8);
      check("age_err0", 32'(digit_err[0]), 32'd0);

      // Accept landing exactly on the wrap that would otherwise expire digit 2
      drive(4'b1011, 7'b1001100, 30);
      drive(4'b1111, 7'b1111111, 1);
      hits = 0;
      for (int i = 0; i < 200 && hits == 0; i++) begin
         if (since_rst % TIMEOUT == 0) hits = 1;
         else step(1);
      end
      step(1);
      for (int i = 0; i < 200 && hits == 1; i++) begin
         if (since_rst % TIMEOUT == TIMEOUT - STABLE - 3) hits = 2;
         else step(1);
      end
      check("wrap_align", 32'(hits), 32'd2);
      drive(4'b1011, 7'b1001100, 30);
      check("wrap_accept_valid2", 32'(digit_valid[2]), 32'd1);
      check("wrap_accept_val2", 32'(digit_val[11:8]), 32'd4);
      check("an_err_sticky", 32'(an_err), 32'd1);

      // Reset in the middle of a settle
      drive(4'b1110, 7'b0000110, 13);
      rst   = 1'b1;
      an_n  = 4'b1111;
      seg_n = 7'b1111111;
      step(1);
      check("mid_rst_val", 32'(digit_val), 32'h0);
      check("mid_rst_valid", 32'(digit_valid), 32'h0);
      check("mid_rst_err", 32'(digit_err), 32'h0);
      check("mid_rst_an_err", 32'(an_err), 32'h0);
      check("mid_rst_update", 32'(update), 32'h0);
      rst = 1'b0;
      u0  = upd_count;
      step(40);
      check("mid_rst_no_update", 32'(upd_count - u0), 32'd0);

      // Randomized traffic against the model
      for (int t = 0; t < 150; t++) begin
         int r;
         r = $urandom_range(0, 99);
         if (r < 70) begin
            a = 4'b0001 << $urandom_range(0, 3);
            a = ~a;
         end else if (r < 85) a = 4'b1111;
         else a = 4'($urandom);
         if ($urandom_range(0, 99) < 70) s = pat_tab[$urandom_range(0, 9)];
         else s = 7'($urandom);
         drive(a, s, $urandom_range(1, 40));
      end
      drive(4'b1111, 7'b1111111, 40);
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
